// File: rtl/ysyx_25060173_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_25060173_pkg
// Shared definitions for the multi-cycle core sequencer:
//   - core_state_t     : sequencer FSM state encoding
//   - RESET_PC_DEFAULT : PC loaded on reset
//   - EBREAK_INST      : encoding of the ebreak instruction
//   - is_ebreak_word() : helper comparing an instruction word to EBREAK_INST
// ---------------------------------------------------------------------------
package ysyx_25060173_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH_REQ  = 3'd1,
        ST_FETCH_WAIT = 3'd2,
        ST_EXEC       = 3'd3,
        ST_HALT       = 3'd4
    } core_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;

    function automatic logic is_ebreak_word(input logic [31:0] w);
        return (w == EBREAK_INST);
    endfunction

endpackage

// File: rtl/ysyx_25060173_core_seq_perf_cnt.sv
// ---------------------------------------------------------------------------
// ysyx_25060173_perf_cnt
// Free-running performance counters for the core sequencer.
//   clk       in   clock
//   rst       in   synchronous active-high reset, clears both counters
//   retire    in   one-cycle pulse per retired instruction
//   cycle_cnt out  cycles since reset (wraps modulo 2^32)
//   instret   out  retired instruction count (wraps modulo 2^32)
// ---------------------------------------------------------------------------
module ysyx_25060173_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        retire,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret
);

    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt <= 32'd0;
            r_instret   <= 32'd0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (retire) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instret   = r_instret;

endmodule

// File: rtl/ysyx_25060173_core_seq.sv
// ---------------------------------------------------------------------------
// ysyx_25060173_core_seq
// Multi-cycle instruction sequencer: fetches one instruction over a
// valid/ready request + valid response memory port, holds it on inst,
// strobes exec for one cycle, then advances pc from the datapath's next_pc.
// An ebreak stops the core in HALT until reset.
//
// Optional feature: define YSYX_25060173_FETCH_TIMEOUT_EN to build a fetch
// watchdog that halts the core (timeout=1, halted=1) after FETCH_TIMEOUT
// cycles in FETCH_WAIT without a response. Without it, FETCH_WAIT waits
// forever and timeout is tied to 0.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   imem_req_valid    out  fetch request valid (FETCH_REQ only)
//   imem_req_ready    in   memory accepts the request
//   imem_req_addr     out  fetch address (= pc)
//   imem_resp_valid   in   fetch data valid
//   imem_resp_data    in   fetched instruction
//   inst              out  latched instruction for the datapath
//   exec              out  one-cycle execute strobe
//   rf_we_en          out  register-file write gate (exec && !is_ebreak)
//   pc                out  current PC
//   next_pc           in   next PC from the datapath
//   is_ebreak         in   decoder flag for inst
//   halted            out  sticky halt flag
//   timeout           out  sticky fetch-timeout flag
//   cycle_cnt         out  cycles since reset
//   instret           out  retired instruction count
// ---------------------------------------------------------------------------
module ysyx_25060173_core_seq
    import ysyx_25060173_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] inst,
    output logic        exec,
    output logic        rf_we_en,
    output logic [31:0] pc,
    input  logic [31:0] next_pc,
    input  logic        is_ebreak,
    output logic        halted,
    output logic        timeout,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret
);

    core_state_t r_state;
    core_state_t w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_halted;
    logic        r_timeout;

    logic        w_req_fire;
    logic        w_resp_take;
    logic        w_wd_expire;

    assign w_req_fire  = (r_state == ST_FETCH_REQ)  && imem_req_ready;
    // Responses are only meaningful in FETCH_WAIT; anything arriving in other
    // states (including the late answer to a fetch abandoned by reset) is ignored.
    assign w_resp_take = (r_state == ST_FETCH_WAIT) && imem_resp_valid;

`ifdef YSYX_25060173_FETCH_TIMEOUT_EN
    logic [31:0] r_wd_cnt;

    // r_wd_cnt holds the number of FETCH_WAIT cycles already spent before the
    // current one, so the FETCH_TIMEOUT-th silent cycle is the one that expires.
    assign w_wd_expire = (r_state == ST_FETCH_WAIT) && !imem_resp_valid &&
                         ((r_wd_cnt + 32'd1) >= 32'(FETCH_TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt <= 32'd0;
        end else if (w_req_fire) begin
            r_wd_cnt <= 32'd0;
        end else if (r_state == ST_FETCH_WAIT) begin
            r_wd_cnt <= r_wd_cnt + 32'd1;
        end
    end
`else
    logic w_unused_fetch_timeout;

    assign w_wd_expire            = 1'b0;
    assign w_unused_fetch_timeout = (FETCH_TIMEOUT != 0);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:       w_state_nxt = ST_FETCH_REQ;
            ST_FETCH_REQ:  if (w_req_fire) w_state_nxt = ST_FETCH_WAIT;
            ST_FETCH_WAIT: begin
                if (w_resp_take) begin
                    w_state_nxt = ST_EXEC;
                end else if (w_wd_expire) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_EXEC:       w_state_nxt = is_ebreak ? ST_HALT : ST_FETCH_REQ;
            ST_HALT:       w_state_nxt = ST_HALT;
            default:       w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req_valid = 1'b0;
        exec           = 1'b0;
        rf_we_en       = 1'b0;
        case (r_state)
            ST_FETCH_REQ: imem_req_valid = 1'b1;
            ST_EXEC: begin
                exec     = 1'b1;
                rf_we_en = !is_ebreak;
            end
            default: ;
        endcase
    end

    // PC, instruction latch and sticky status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_inst    <= 32'd0;
            r_halted  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_resp_take) begin
                r_inst <= imem_resp_data;
            end
            if (r_state == ST_EXEC) begin
                if (is_ebreak) begin
                    r_halted <= 1'b1;
                end else begin
                    r_pc <= next_pc;
                end
            end
            if (w_wd_expire) begin
                r_timeout <= 1'b1;
                r_halted  <= 1'b1;
            end
        end
    end

    ysyx_25060173_perf_cnt u_perf (
        .clk       (clk),
        .rst       (rst),
        .retire    (exec),
        .cycle_cnt (cycle_cnt),
        .instret   (instret)
    );

    assign imem_req_addr = r_pc;
    assign pc            = r_pc;
    assign inst          = r_inst;
    assign halted        = r_halted;
    assign timeout       = r_timeout;

endmodule

// File: tb/tb_ysyx_25060173_core_seq.sv
module tb_ysyx_25060173_core_seq;
    import ysyx_25060173_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic [31:0] inst;
    logic        exec;
    logic        rf_we_en;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        is_ebreak;
    logic        halted;
    logic        timeout;
    logic [31:0] cycle_cnt;
    logic [31:0] instret;

    // Minimal datapath stand-in: sequential next PC and an ebreak decoder.
    assign next_pc   = pc + 32'd4;
    assign is_ebreak = is_ebreak_word(inst);

    ysyx_25060173_core_seq #(
        .RESET_PC      (RST_PC),
        .FETCH_TIMEOUT (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst            (inst),
        .exec            (exec),
        .rf_we_en        (rf_we_en),
        .pc              (pc),
        .next_pc         (next_pc),
        .is_ebreak       (is_ebreak),
        .halted          (halted),
        .timeout         (timeout),
        .cycle_cnt       (cycle_cnt),
        .instret         (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } sb_t;

    typedef struct {
        logic [31:0] word;
        int          stall;
        int          lat;
        logic        exp_we;
    } vec_t;

    sb_t         sb[$];
    vec_t        vecs[5];
    int          checks = 0;
    int          fails  = 0;
    int          tick_n = 0;
    int          last_exec_tick = 0;
    bit          have_last = 0;
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] exp_instret = 32'd0;
    logic [31:0] cyc_exp = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        if (rst) cyc_exp = 32'd0;
        else     cyc_exp = cyc_exp + 32'd1;
        tick_n++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        tick();
        chk("reset_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("reset_exec", {31'd0, exec}, 32'd0);
        chk("reset_we", {31'd0, rf_we_en}, 32'd0);
        chk("reset_pc", pc, RST_PC);
        chk("reset_inst", inst, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_timeout", {31'd0, timeout}, 32'd0);
        chk("reset_cycle_cnt", cycle_cnt, 32'd0);
        chk("reset_instret", instret, 32'd0);
        rst = 1'b0;
        exp_pc      = RST_PC;
        exp_instret = 32'd0;
        have_last   = 0;
        sb.delete();
    endtask

    // One full fetch/execute: wait for the request, hold ready low for
    // 'stall' cycles, answer 'lat' cycles after acceptance, check the exec.
    task automatic do_fetch(input logic [31:0] word, input int stall, input int lat,
                            input logic exp_we);
        int  n;
        sb_t e;
        n = 0;
        while (!imem_req_valid && n < 16) begin
            tick();
            n++;
        end
        chk("req_valid_seen", {31'd0, imem_req_valid}, 32'd1);
        for (int i = 0; i < stall; i++) begin
            imem_req_ready = 1'b0;
            tick();
            chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("stall_addr", imem_req_addr, exp_pc);
            chk("stall_exec", {31'd0, exec}, 32'd0);
        end
        imem_req_ready = 1'b1;
        chk("req_addr", imem_req_addr, exp_pc);
        tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < lat; i++) begin
            chk("wait_exec", {31'd0, exec}, 32'd0);
            chk("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
            tick();
        end
        imem_resp_valid = 1'b1;
        imem_resp_data  = word;
        sb.push_back('{pc: exp_pc, inst: word});
        tick();
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        chk("exec_strobe", {31'd0, exec}, 32'd1);
        if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL scoreboard_empty actual=0 required=1");
        end else begin
            e = sb.pop_front();
            chk("exec_inst", inst, e.inst);
            chk("exec_pc", pc, e.pc);
        end
        chk("exec_we", {31'd0, rf_we_en}, {31'd0, exp_we});
        if (have_last)
            chk("exec_gap", 32'(tick_n - last_exec_tick), 32'(3 + stall + lat));
        last_exec_tick = tick_n;
        have_last = 1;
        tick();
        exp_instret = exp_instret + 32'd1;
        if (word != EBREAK_INST) exp_pc = exp_pc + 32'd4;
        chk("post_exec", {31'd0, exec}, 32'd0);
        chk("post_pc", pc, exp_pc);
        chk("post_instret", instret, exp_instret);
        chk("post_halted", {31'd0, halted}, {31'd0, word == EBREAK_INST});
        chk("post_cycle_cnt", cycle_cnt, cyc_exp);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", tick_n);
        $fatal(1, "simulation time limit");
    end

    initial begin
        vecs[0] = '{word: 32'h0010_0093, stall: 0, lat: 0, exp_we: 1'b1};
        vecs[1] = '{word: 32'h0020_0113, stall: 0, lat: 0, exp_we: 1'b1};
        vecs[2] = '{word: 32'h0000_0013, stall: 0, lat: 2, exp_we: 1'b1};
        vecs[3] = '{word: 32'h0040_0213, stall: 3, lat: 1, exp_we: 1'b1};
        vecs[4] = '{word: EBREAK_INST,   stall: 0, lat: 0, exp_we: 1'b0};

        // Program run: immediate fetches, latencies, stalls, ending in ebreak.
        do_reset();
        tick();
        chk("idle_to_req", {31'd0, imem_req_valid}, 32'd1);
        chk("first_cycle_cnt", cycle_cnt, 32'd1);
        for (int i = 0; i < 5; i++) begin
            do_fetch(vecs[i].word, vecs[i].stall, vecs[i].lat, vecs[i].exp_we);
            if (i == 0) begin
                chk("first_pc_advance", pc, 32'h8000_0004);
                chk("first_instret", instret, 32'd1);
            end
        end

        // Halted: no requests, no exec, stray responses dropped.
        for (int i = 0; i < 5; i++) begin
            imem_resp_valid = i[0];
            imem_resp_data  = 32'h0070_0393;
            tick();
            chk("halt_req_valid", {31'd0, imem_req_valid}, 32'd0);
            chk("halt_exec", {31'd0, exec}, 32'd0);
            chk("halt_we", {31'd0, rf_we_en}, 32'd0);
            chk("halt_inst", inst, EBREAK_INST);
            chk("halt_pc", pc, exp_pc);
            chk("halt_cycle_cnt", cycle_cnt, cyc_exp);
        end
        imem_resp_valid = 1'b0;

        // Cycle counter wrap while halted.
        dut.u_perf.r_cycle_cnt = 32'hFFFF_FFFE;
        cyc_exp = 32'hFFFF_FFFE;
        tick();
        chk("wrap_max", cycle_cnt, 32'hFFFF_FFFF);
        tick();
        chk("wrap_zero", cycle_cnt, 32'd0);
        tick();
        chk("wrap_one", cycle_cnt, 32'd1);
        chk("wrap_instret", instret, exp_instret);
        chk("wrap_pc", pc, exp_pc);
        chk("wrap_halted", {31'd0, halted}, 32'd1);

        // Ready held low for 4 cycles on the first fetch.
        do_reset();
        do_fetch(32'h0010_0093, 4, 0, 1'b1);

        // Reset while a fetch is outstanding; the late response is dropped.
        while (!imem_req_valid) tick();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst_wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_wait_exec", {31'd0, exec}, 32'd0);
        chk("rst_wait_pc", pc, RST_PC);
        chk("rst_wait_inst", inst, 32'd0);
        chk("rst_wait_instret", instret, 32'd0);
        rst = 1'b0;
        exp_pc = RST_PC;
        exp_instret = 32'd0;
        have_last = 0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0050_0293;
        tick();
        imem_resp_valid = 1'b0;
        chk("late_resp_inst", inst, 32'd0);
        chk("late_resp_exec", {31'd0, exec}, 32'd0);
        chk("restart_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("restart_addr", imem_req_addr, RST_PC);
        do_fetch(32'h0060_0313, 0, 0, 1'b1);

        // Fetch watchdog.
        do_reset();
        while (!imem_req_valid) tick();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
`ifdef YSYX_25060173_FETCH_TIMEOUT_EN
        for (int i = 0; i < 7; i++) tick();
        chk("wd_before_halted", {31'd0, halted}, 32'd0);
        chk("wd_before_timeout", {31'd0, timeout}, 32'd0);
        tick();
        chk("wd_timeout", {31'd0, timeout}, 32'd1);
        chk("wd_halted", {31'd0, halted}, 32'd1);
        tick();
        chk("wd_no_req", {31'd0, imem_req_valid}, 32'd0);
        chk("wd_no_exec", {31'd0, exec}, 32'd0);
`else
        begin
            int exec_seen;
            exec_seen = 0;
            for (int i = 0; i < 300; i++) begin
                tick();
                if (exec) exec_seen++;
            end
            chk("nowd_exec", 32'(exec_seen), 32'd0);
            chk("nowd_timeout", {31'd0, timeout}, 32'd0);
            chk("nowd_halted", {31'd0, halted}, 32'd0);
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'h0080_0413;
            tick();
            imem_resp_valid = 1'b0;
            chk("nowd_exec_late", {31'd0, exec}, 32'd1);
            chk("nowd_inst", inst, 32'h0080_0413);
        end
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_25060173_core_seq.md
YSYX_25060173_CORE_SEQ -- requirements
Module: ysyx_25060173_core_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000: PC loaded on reset.
REQ-002 SHALL have parameter FETCH_TIMEOUT, default 255: max FETCH_WAIT cycles before timeout halt (macro builds only).
REQ-003 SHALL have port clk  in  1  clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port imem_req_valid  out  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  in  1  memory accepts request.
REQ-007 SHALL have port imem_req_addr  out  32  fetch address, equal to pc.
REQ-008 SHALL have port imem_resp_valid  in  1  fetch data valid.
REQ-009 SHALL have port imem_resp_data  in  32  fetched instruction.
REQ-010 SHALL have port inst  out  32  latched instruction driven to the datapath.
REQ-011 SHALL have port exec  out  1  one-cycle execute strobe.
REQ-012 SHALL have port rf_we_en  out  1  register-file write gate, high only during exec.
REQ-013 SHALL have port pc  out  32  current PC.
REQ-014 SHALL have port next_pc  in  32  next PC computed by the datapath.
REQ-015 SHALL have port is_ebreak  in  1  decoder flag for the current inst.
REQ-016 SHALL have port halted  out  1  sticky halt flag.
REQ-017 SHALL have port timeout  out  1  sticky fetch-timeout flag.
REQ-018 SHALL have port cycle_cnt  out  32  cycles since reset.
REQ-019 SHALL have port instret  out  32  count of retired instructions.

Function
REQ-020 SHALL implement FSM states IDLE, FETCH_REQ, FETCH_WAIT, EXEC and HALT.
REQ-021 SHALL transition IDLE->FETCH_REQ unconditionally after one cycle.
REQ-022 SHALL assert imem_req_valid only in FETCH_REQ, hold imem_req_addr stable until imem_req_valid&&imem_req_ready, then enter FETCH_WAIT.
REQ-023 SHALL sample imem_resp_valid only in FETCH_WAIT, latch imem_resp_data into inst, then enter EXEC; a response in any other state SHALL be dropped.
REQ-024 SHALL hold EXEC for exactly one cycle with exec=1, and rf_we_en=!is_ebreak.
REQ-025 SHALL, on EXEC with is_ebreak=0, load pc<=next_pc and go to FETCH_REQ.
REQ-026 SHALL, on EXEC with is_ebreak=1, keep pc, set halted=1 and go to HALT.
REQ-027 SHALL remain in HALT until rst, with imem_req_valid=0, exec=0 and rf_we_en=0.
REQ-028 SHALL deliver a minimum of 3 cycles per instruction (ready and response both immediate).
REQ-029 SHALL increment cycle_cnt every cycle outside reset, including HALT; it SHALL wrap modulo 2^32.
REQ-030 SHALL increment instret on every EXEC cycle, ebreak included; it SHALL wrap modulo 2^32.
REQ-031 SHALL keep inst unchanged outside FETCH_WAIT-to-EXEC latching.

Reset
REQ-032 SHALL, on rst in any state, next cycle set: state=IDLE; pc=RESET_PC; inst=0; exec=0; rf_we_en=0; imem_req_valid=0; halted=0; timeout=0; cycle_cnt=0; instret=0.
REQ-033 SHALL treat a fetch outstanding at reset as abandoned; its late response SHALL be ignored.

Configuration
REQ-034 SHALL compile the fetch watchdog only when YSYX_25060173_FETCH_TIMEOUT_EN is defined.
REQ-035 SHALL, with the macro defined, count FETCH_WAIT cycles, clearing the count on FETCH_WAIT entry.
REQ-036 SHALL, with the macro defined, on reaching FETCH_TIMEOUT with no response, set timeout=1 and halted=1 and enter HALT.
REQ-037 SHALL, without the macro, wait indefinitely in FETCH_WAIT, tie timeout to 0 and ignore FETCH_TIMEOUT.

Structure
REQ-038 SHALL take the FSM state typedef/encoding, the RESET_PC default and the EBREAK encoding 32'h0010_0073 from shared package ysyx_25060173_pkg.
REQ-039 SHALL place cycle_cnt/instret in sub-module ysyx_25060173_perf_cnt (inputs: clk, rst, retire).

Verification
REQ-040 SHALL cover: ready=1 and one-cycle response returning 32'h0010_0093 -> exec every 3rd cycle, pc 80000000->80000004, instret=1.
REQ-041 SHALL cover: imem_req_ready low for 4 cycles -> imem_req_valid held, addr stable at 32'h8000_0000, no exec.
REQ-042 SHALL cover: fetch returns 32'h0010_0073 -> one exec cycle with rf_we_en=0, halted=1, pc unchanged, no further requests.
REQ-043 SHALL cover: rst asserted in FETCH_WAIT, response arrives the next cycle -> response dropped, pc=32'h8000_0000, FSM restarts from IDLE.
REQ-044 SHALL cover, with the macro defined and FETCH_TIMEOUT=8: no response -> timeout=1 and halted=1 after 8 FETCH_WAIT cycles.
REQ-045 SHALL cover: cycle_cnt preset near 32'hFFFF_FFFF -> wraps to 0 with no other side effect.
